// File: rtl/micro_ucr_nonce_search.sv
// Nonce search controller: latches a block and a target, sweeps nonces into the
// hash core and stops on the first hash that meets the target or at MAX_NONCE.
module micro_ucr_nonce_search #(
    parameter int unsigned HASH_LATENCY = 1,
    parameter logic [31:0] NONCE_START  = 32'h0000_0000,
    parameter logic [31:0] MAX_NONCE    = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [95:0] bloque_bytes,
    input  logic [7:0]  target,
    input  logic [23:0] hash_value,
    output logic [95:0] hash_bloque,
    output logic [31:0] hash_nonce,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [31:0] nonce,
    output logic [23:0] hash
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [3:0] LAT = 4'(HASH_LATENCY);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] tgt;
    logic [3:0] lat_cnt;
    logic       cmp_cycle;
    logic       hash_ok;
    logic       at_max;

    // Only the two upper hash bytes take part in the difficulty test.
    function automatic logic meets_target(input logic [15:0] h_hi, input logic [7:0] t);
        return (h_hi[15:8] < t) && (h_hi[7:0] < t);
    endfunction

    assign cmp_cycle = (lat_cnt == LAT);
    assign hash_ok   = meets_target(hash_value[23:8], tgt);
    assign at_max    = (hash_nonce == MAX_NONCE);

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (abort || (cmp_cycle && (hash_ok || at_max))) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            hash_bloque <= '0;
            hash_nonce  <= '0;
            lat_cnt     <= '0;
            found       <= 1'b0;
            nonce       <= '0;
            hash        <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        hash_bloque <= bloque_bytes;
                        hash_nonce  <= NONCE_START;
                        lat_cnt     <= '0;
                        found       <= 1'b0;
                        nonce       <= '0;
                        hash        <= '0;
                    end
                end
                WAIT: begin
                    // abort takes priority over a compare landing in the same cycle
                    if (abort) begin
                        found <= 1'b0;
                        nonce <= hash_nonce;
                        hash  <= '0;
                    end else if (cmp_cycle) begin
                        if (hash_ok) begin
                            found <= 1'b1;
                            nonce <= hash_nonce;
                            hash  <= hash_value;
                        end else if (at_max) begin
                            found <= 1'b0;
                            nonce <= MAX_NONCE;
                            hash  <= hash_value;
                        end else begin
                            hash_nonce <= hash_nonce + 32'd1;
                            lat_cnt    <= '0;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Target is data-only: captured on an accepted start, never cleared.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) tgt <= target;
    end

endmodule

// File: tb/tb_micro_ucr_nonce_search.sv
// Bench for micro_ucr_nonce_search: four instances with different parameters,
// each driven by a stub hash core, checked against a scoreboard of expected results.
module tb_micro_ucr_nonce_search;

    typedef struct {
        int          cyc;
        logic        found;
        logic [31:0] nonce;
        logic [23:0] hash;
        logic [95:0] blk;
    } exp_t;

    localparam logic [95:0] B1 = 96'h0123_4567_89AB_CDEF_0011_2233;
    localparam logic [95:0] B2 = 96'hDEAD_BEEF_CAFE_F00D_1234_5678;
    localparam logic [95:0] B3 = 96'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3;
    localparam logic [95:0] B4 = 96'h1111_2222_3333_4444_5555_6666;
    localparam logic [95:0] B5 = 96'hFFFF_0000_FFFF_0000_FFFF_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start [4];
    logic        abort [4];
    logic [95:0] blk   [4];
    logic [7:0]  tgt   [4];
    logic [23:0] hv    [4];
    logic [95:0] hb    [4];
    logic [31:0] hn    [4];
    logic        busy  [4];
    logic        done  [4];
    logic        found [4];
    logic [31:0] non   [4];
    logic [23:0] hsh   [4];

    int   cnt = 0;
    int   errors = 0;
    int   checks = 0;
    int   t0;
    exp_t sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cnt <= cnt + 1;

    for (genvar g = 0; g < 4; g++) begin : g_inst
        localparam int unsigned L = (g == 3) ? 3 : ((g == 2) ? 0 : 1);
        logic [23:0] stub_now;
        logic [23:0] dly [16];
        assign stub_now = {8'hFF - hn[g][7:0], 16'h0000};
        always @(posedge clk) begin
            dly[0] <= stub_now;
            for (int i = 1; i < 16; i++) dly[i] <= dly[i-1];
        end
        if (L == 0) begin : g_comb
            assign hv[g] = stub_now;
        end else begin : g_dly
            assign hv[g] = dly[L-1];
        end
        micro_ucr_nonce_search #(
            .HASH_LATENCY(L),
            .NONCE_START (g == 2 ? 32'h0000_00FF : 32'h0000_0000),
            .MAX_NONCE   (g == 1 ? 32'h0000_000F : 32'hFFFF_FFFF)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .start       (start[g]),
            .abort       (abort[g]),
            .bloque_bytes(blk[g]),
            .target      (tgt[g]),
            .hash_value  (hv[g]),
            .hash_bloque (hb[g]),
            .hash_nonce  (hn[g]),
            .busy        (busy[g]),
            .done        (done[g]),
            .found       (found[g]),
            .nonce       (non[g]),
            .hash        (hsh[g])
        );
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input int g, input string tag);
        chk($sformatf("%s[%0d] hash_bloque", tag, g), hb[g], '0);
        chk($sformatf("%s[%0d] hash_nonce", tag, g), hn[g], '0);
        chk($sformatf("%s[%0d] busy", tag, g), busy[g], '0);
        chk($sformatf("%s[%0d] done", tag, g), done[g], '0);
        chk($sformatf("%s[%0d] found", tag, g), found[g], '0);
        chk($sformatf("%s[%0d] nonce", tag, g), non[g], '0);
        chk($sformatf("%s[%0d] hash", tag, g), hsh[g], '0);
    endtask

    // Called at a falling edge: that cycle is cycle 0; returns at cycle 1.
    task automatic launch(input int g, input logic [95:0] b, input logic [7:0] t, output int t_start);
        blk[g]   = b;
        tgt[g]   = t;
        start[g] = 1'b1;
        t_start  = cnt;
        @(negedge clk);
        start[g] = 1'b0;
        chk($sformatf("launch[%0d] busy", g), busy[g], 1'b1);
        chk($sformatf("launch[%0d] done", g), done[g], 1'b0);
    endtask

    task automatic finish(input int g, input int t_start, input string tag);
        int   cyc;
        exp_t e;
        cyc = -1;
        for (int i = 0; i < 2000; i++) begin
            if (done[g]) begin
                cyc = cnt - t_start;
                break;
            end
            @(negedge clk);
        end
        if (sb.size() == 0) begin
            chk({tag, " scoreboard"}, 128'(sb.size()), 128'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, " done_cycle"}, 128'(cyc), 128'(e.cyc));
        chk({tag, " found"}, found[g], e.found);
        chk({tag, " nonce"}, non[g], e.nonce);
        chk({tag, " hash"}, hsh[g], e.hash);
        chk({tag, " hash_bloque"}, hb[g], e.blk);
        chk({tag, " busy_in_done"}, busy[g], 1'b0);
        @(negedge clk);
        chk({tag, " done_one_cycle"}, done[g], 1'b0);
        chk({tag, " busy_after"}, busy[g], 1'b0);
        chk({tag, " found_hold"}, found[g], e.found);
    endtask

    initial begin
        reset = 1'b1;
        for (int g = 0; g < 4; g++) begin
            start[g] = 1'b0;
            abort[g] = 1'b0;
            blk[g]   = '0;
            tgt[g]   = '0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 4; g++) chk_zero(g, "reset");
        reset = 1'b0;
        @(negedge clk);

        // L=1 full sweep, first hit at nonce F0
        sb.push_back('{483, 1'b1, 32'h0000_00F0, 24'h0F_0000, B1});
        launch(0, B1, 8'h10, t0);
        finish(0, t0, "t1");

        // target 0 exhausts a 16-nonce range
        sb.push_back('{33, 1'b0, 32'h0000_000F, 24'hF0_0000, B2});
        launch(1, B2, 8'h00, t0);
        finish(1, t0, "t2");

        // L=0, first candidate hits
        sb.push_back('{2, 1'b1, 32'h0000_00FF, 24'h00_0000, B3});
        launch(2, B3, 8'h01, t0);
        finish(2, t0, "t3");

        // L=3, abort at cycle 20 together with an ignored start
        sb.push_back('{21, 1'b0, 32'h0000_0004, 24'h00_0000, B4});
        launch(3, B4, 8'h10, t0);
        repeat (19) @(negedge clk);
        chk("t4 cycle20 nonce", hn[3], 32'h4);
        abort[3] = 1'b1;
        start[3] = 1'b1;
        blk[3]   = B5;
        tgt[3]   = 8'hFF;
        @(negedge clk);
        abort[3] = 1'b0;
        start[3] = 1'b0;
        finish(3, t0, "t4");

        // reset in mid-search clears everything, rerun reproduces t1
        launch(0, B1, 8'h10, t0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_zero(0, "t5_reset");
        reset = 1'b0;
        @(negedge clk);
        sb.push_back('{483, 1'b1, 32'h0000_00F0, 24'h0F_0000, B1});
        launch(0, B1, 8'h10, t0);
        finish(0, t0, "t5");

        // start held through busy and done cycles is ignored
        sb.push_back('{2, 1'b1, 32'h0000_00FF, 24'h00_0000, B3});
        launch(2, B3, 8'h01, t0);
        start[2] = 1'b1;
        blk[2]   = B5;
        tgt[2]   = 8'h00;
        finish(2, t0, "t6");
        start[2] = 1'b0;
        @(negedge clk);
        chk("t6 busy_later", busy[2], 1'b0);
        chk("t6 nonce_hold", non[2], 32'h0000_00FF);
        chk("t6 hash_hold", hsh[2], 24'h00_0000);
        chk("t6 bloque_hold", hb[2], B3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
